// File: rtl/i2c_byte_ctrl.sv
// rtl/i2c_byte_ctrl.sv - I2C byte-level master controller (START/STOP/WRITE/READ)
//
// Executes one bus command at a time, pacing SCL/SDA from an external
// bit-rate divider that delivers alternating sample_h / sample_l strobes.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake; cmd 00 START, 01 STOP, 10 WRITE, 11 READ
//   wr_data, rd_ack_in  WRITE byte (MSB first) and ACK bit sent after a READ byte
//   done, err           one-cycle completion pulse, err marks a rejected command
//   rd_data, ack_out    last READ byte, slave ACK sampled after the last WRITE
//   busy                controller not idle
//   en_clk              enables the external divider
//   sample_h, sample_l  divider strobes (raise SCL / sample and lower SCL)
//   scl_o, sda_oe       SCL level, SDA pull-down enable
//   sda_i               SDA pin level
module i2c_byte_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_ack_in,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       ack_out,
    output logic       busy,
    output logic       en_clk,
    input  logic       sample_h,
    input  logic       sample_l,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RSTART, S_STOP, S_XFER, S_DONE
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  data_q, data_d;
    logic        rdack_q, rdack_d;
    logic        err_q, err_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ack_q, ack_d;

    // Strobes only count while the divider is enabled; sample_h wins a tie.
    logic str_h, str_l;
    assign str_h = en_clk & sample_h;
    assign str_l = en_clk & sample_l & ~sample_h;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cmd_q     <= 2'b00;
            data_q    <= 8'h00;
            rdack_q   <= 1'b0;
            err_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b0;
            rd_data_q <= 8'h00;
            ack_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            rdack_q   <= rdack_d;
            err_q     <= err_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        rdack_d   = rdack_q;
        err_d     = err_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        rd_data_d = rd_data_q;
        ack_d     = ack_q;

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    data_d  = wr_data;
                    rdack_d = rd_ack_in;
                    cnt_d   = 4'd0;
                    case (cmd)
                        CMD_START: begin
                            // SCL already low means we are mid-transfer: repeated start.
                            if (scl_q) begin
                                state_d = S_START;
                            end else begin
                                state_d = S_RSTART;
                                sda_d   = 1'b0;
                            end
                        end
                        CMD_STOP: begin
                            state_d = S_STOP;
                            if (scl_q) err_d = 1'b1;
                            else       sda_d = 1'b1;
                        end
                        default: begin
                            // WRITE/READ need a preceding START (SCL held low).
                            state_d = S_XFER;
                            if (scl_q)                 err_d = 1'b1;
                            else if (cmd == CMD_WRITE) sda_d = ~wr_data[7];
                            else                       sda_d = 1'b0;
                        end
                    endcase
                end
            end

            S_START: begin
                if (err_q) begin
                    state_d = S_DONE;
                end else if (str_h) begin
                    sda_d = 1'b1;
                end else if (str_l && sda_q) begin
                    scl_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_RSTART: begin
                // SCL/SDA levels tell which of the three phases we are in.
                if (err_q) begin
                    state_d = S_DONE;
                end else if (str_h) begin
                    if (!scl_q) begin
                        scl_d = 1'b1;
                    end else if (sda_q) begin
                        scl_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end else if (str_l && scl_q) begin
                    sda_d = 1'b1;
                end
            end

            S_STOP: begin
                if (err_q) begin
                    state_d = S_DONE;
                end else if (str_h) begin
                    scl_d = 1'b1;
                end else if (str_l && scl_q) begin
                    sda_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_XFER: begin
                if (err_q) begin
                    state_d = S_DONE;
                end else if (str_h) begin
                    scl_d = 1'b1;
                end else if (str_l) begin
                    scl_d = 1'b0;
                    if (cnt_q == 4'd8) begin
                        state_d = S_DONE;
                        if (cmd_q == CMD_READ) rd_data_d = data_q;
                        else                   ack_d     = sda_i;
                    end else begin
                        // One shift register serves both directions: READ shifts the
                        // sampled bit in, WRITE takes its next bit from data_q[6].
                        data_d = {data_q[6:0], sda_i};
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd7)
                            sda_d = (cmd_q == CMD_READ) ? ~rdack_q : 1'b0;
                        else
                            sda_d = (cmd_q == CMD_READ) ? 1'b0 : ~data_q[6];
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && err_q;
        en_clk    = ((state_q == S_START) || (state_q == S_RSTART) ||
                     (state_q == S_STOP)  || (state_q == S_XFER)) && !err_q;
        rd_data   = rd_data_q;
        ack_out   = ack_q;
        scl_o     = scl_q;
        sda_oe    = sda_q;
    end

endmodule

// File: doc/i2c_byte_ctrl.md
I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

Interface
REQ-001 SHALL have these ports: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-002 SHALL have these command ports.
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ
- wr_data  in  8  WRITE byte, MSB first
- rd_ack_in  in  1  ACK bit driven after a READ byte; 0 = ACK
REQ-003 SHALL have these result ports.
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse with done; command rejected
- rd_data  out  8  READ byte, held until the next READ completes
- ack_out  out  1  slave ACK sampled after WRITE; 0 = ACK
- busy  out  1  state != IDLE
REQ-004 SHALL have these divider and bus ports.
- en_clk  out  1  enables the bit-rate divider
- sample_h  in  1  divider strobe
- sample_l  in  1  divider strobe
- scl_o  out  1  SCL level
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA
- sda_i  in  1  SDA pin level

Function
REQ-005 SHALL implement the states IDLE, START, RSTART, STOP, XFER and DONE.
REQ-006 SHALL assert cmd_ready only in IDLE and SHALL latch cmd, wr_data and rd_ack_in on accept.
REQ-007 SHALL drive en_clk high from the cycle after accept through the cycle of the final strobe, and low in IDLE and DONE.
REQ-008 SHALL act only on strobes while en_clk=1 and SHALL ignore strobes in IDLE and DONE.
REQ-009 SHALL NOT assume strobe spacing; the divider alternates strobes, sample_h first after enable.
REQ-010 START with scl_o=1:
- on sample_h: sda_oe<=1
- on the next sample_l: scl_o<=0, then DONE
REQ-011 START with scl_o=0 (RSTART):
- on accept: sda_oe<=0
- on sample_h: scl_o<=1
- on sample_l: sda_oe<=1
- on the next sample_h: scl_o<=0, then DONE
REQ-012 STOP with scl_o=0:
- on accept: sda_oe<=1
- on sample_h: scl_o<=1
- on sample_l: sda_oe<=0, then DONE
REQ-013 STOP with scl_o=1 SHALL leave the bus unchanged and complete with err=1.
REQ-014 WRITE or READ with scl_o=1 (no START) SHALL complete with err=1 and no bus change.
- The err/done pulse SHALL occur 2 cycles after accept, via DONE, with en_clk never asserted.
REQ-015 XFER SHALL use a 4-bit counter of 9 bit slots, 0..8. Per slot:
- on sample_h: scl_o<=1
- on sample_l: sample sda_i, scl_o<=0, counter +1, drive the next slot's SDA
REQ-016 WRITE SDA drive:
- slot 0 SDA SHALL be driven on accept: sda_oe = ~wr_data[7]
- slots 1..7 SHALL drive ~wr_data[7-i]
- slot 8 SHALL release SDA, and sda_i sampled in slot 8 SHALL become ack_out
REQ-017 READ SDA drive:
- slots 0..7 SHALL release SDA and shift sda_i into rd_data MSB-first
- slot 8 SHALL drive sda_oe = ~rd_ack_in
REQ-018 After the slot-8 sample_l, XFER SHALL go to DONE with scl_o=0 and sda_oe unchanged.
REQ-019 DONE SHALL last one cycle, pulse done (plus err where specified), and return to IDLE.
- cmd_ready SHALL be high in the following cycle.
REQ-020 SHALL ignore the impossible simultaneous sample_h and sample_l; sample_h takes priority.
REQ-021 SHALL ignore cmd_valid while busy; commands SHALL NOT be queued.

Reset
REQ-022 rst SHALL force, at the next clk edge from any state (including mid-byte):
- state IDLE, counter 0
- en_clk 0, scl_o 1, sda_oe 0
- done 0, err 0, busy 0
- rd_data 8'h00, ack_out 1
REQ-023 cmd_ready SHALL be 1 in the first cycle after reset release.
REQ-024 No latched command SHALL survive reset.

Verification
REQ-025 Strobe reference: the companion divider model has its first strobe (sample_h) 5 cycles after en_clk rises, then strobes every 6 cycles.
REQ-026 START from reset -> on sample_h sda_oe=1, on sample_l scl_o=0, done pulses 1 cycle later, err=0, en_clk=0 in DONE.
REQ-027 START, then WRITE 8'hA5 with a slave model ACKing -> SDA pattern on SCL high phases is 1,0,1,0,0,1,0,1, slot 8 released, ack_out=0, done once, total 18 strobes for the WRITE.
REQ-028 READ with a slave driving 8'h3C and rd_ack_in=1 -> rd_data=8'h3C at done, sda_oe=0 for all 9 slots.
REQ-029 STOP after a byte -> sda_oe=1 then scl_o=1 on sample_h, then sda_oe=0 on sample_l (SDA rises while SCL high), busy=0 after done.
REQ-030 WRITE from idle with no START -> err=1 and done=1 together 2 cycles after accept; scl_o stays 1 and sda_oe stays 0 throughout.
REQ-031 rst asserted after the slot-4 sample_l of a WRITE -> next cycle en_clk=0, scl_o=1, sda_oe=0, cmd_ready=1, and no done pulse.
